// File: rtl/phy_mgmt_pkg.sv
// Shared types and constants for the PHY management scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package phy_mgmt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_ISS,
        ST_RST_WAIT,
        ST_CFG_ISS,
        ST_CFG_WAIT,
        ST_BMSR_ISS,
        ST_BMSR_WAIT,
        ST_SPD_ISS,
        ST_SPD_WAIT
    } state_t;

    localparam logic [4:0] REG_BMCR      = 5'h00;
    localparam logic [4:0] REG_BMSR      = 5'h01;
    localparam int         BMSR_LINK_BIT = 2;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;

    // Link-status bit of a BMSR read.
    function automatic logic bmsr_link(input logic [15:0] bmsr);
        return bmsr[BMSR_LINK_BIT];
    endfunction

endpackage

// File: rtl/phy_poll_timer.sv
// Free-running reload down-counter that paces the periodic link/speed poll.
// Latency: poll_tick high for one cycle every POLL_CYCLES clocks, first one POLL_CYCLES-1 clocks after reset.
// Backpressure: none; the consumer latches the tick into its own pending flag.
// Ports: clk, rst_n (async active-low) in; poll_tick out (combinational decode of count == 0).
module phy_poll_timer #(
    parameter int POLL_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    output logic poll_tick
);

    localparam int               CW     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CW-1:0]    RELOAD = CW'(POLL_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign poll_tick = (cnt == '0);

endmodule

// File: rtl/phy_mgmt_sched.sv
// MDIO transaction scheduler: arbitrates soft reset > host cfg > periodic poll onto one driver port, publishes link/speed.
// Latency: request seen in IDLE launches op_exec next cycle; op_done/timeout is reflected in outputs one cycle later.
// Backpressure: one operation in flight; cfg_req is held until cfg_ack, reset/poll requests wait in pending flags.
// Ports: soft_rst_trig, cfg_* host port, op_* driver port, link_up/speed/status_valid status, busy/err indicators.
module phy_mgmt_sched
    import phy_mgmt_pkg::*;
#(
    parameter logic [15:0] PHY_RST_DATA   = 16'h9140,
    parameter logic [4:0]  SPEED_REG      = 5'h11,
    parameter int          SPEED_LSB      = 14,
    parameter int          POLL_CYCLES    = 500000,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_rst_trig,
    input  logic        cfg_req,
    input  logic        cfg_rh_wl,
    input  logic [4:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic        cfg_ack,
    output logic [15:0] cfg_rdata,
    output logic        op_exec,
    output logic        op_rh_wl,
    output logic [4:0]  op_addr,
    output logic [15:0] op_wr_data,
    input  logic        op_done,
    input  logic [15:0] op_rd_data,
    input  logic        op_rd_ack,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        status_valid,
    output logic        busy,
    output logic        err
);

    localparam int            TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic          rst_pend;
    logic          poll_pend;
    logic          poll_tick;
    logic [TW-1:0] wait_cnt;

    logic rst_req, poll_req, in_idle, go_rst, go_cfg, go_poll;
    logic in_wait, wait_tmo, rd_ok;

    phy_poll_timer #(
        .POLL_CYCLES (POLL_CYCLES)
    ) u_poll_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .poll_tick (poll_tick)
    );

    // Raw triggers take part in this cycle's arbitration so a trigger that
    // coincides with a host request still wins on the same edge.
    assign rst_req  = rst_pend | soft_rst_trig;
    assign poll_req = poll_pend | poll_tick;
    assign in_idle  = (state == ST_IDLE);
    assign go_rst   = in_idle & rst_req;
    assign go_cfg   = in_idle & ~rst_req & cfg_req;
    assign go_poll  = in_idle & ~rst_req & ~cfg_req & poll_req;

    assign in_wait  = (state == ST_RST_WAIT)  || (state == ST_CFG_WAIT) ||
                      (state == ST_BMSR_WAIT) || (state == ST_SPD_WAIT);
    assign wait_tmo = in_wait && (wait_cnt == WAIT_LAST);
    assign rd_ok    = op_done & ~op_rd_ack;

    // Pending flags: a trigger while already pending merges; launch clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pend  <= 1'b0;
            poll_pend <= 1'b0;
        end else begin
            rst_pend  <= rst_req & ~go_rst;
            poll_pend <= poll_req & ~go_poll;
        end
    end

    // Wait counter restarts at 0 on every WAIT entry (every WAIT is preceded
    // by an ISS cycle, which holds it at 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_exec      <= 1'b0;
            op_rh_wl     <= 1'b1;
            op_addr      <= '0;
            op_wr_data   <= '0;
            cfg_ack      <= 1'b0;
            cfg_rdata    <= '0;
            link_up      <= 1'b0;
            speed        <= SPD_10;
            status_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            op_exec <= 1'b0;
            cfg_ack <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go_rst) begin
                        state      <= ST_RST_ISS;
                        op_exec    <= 1'b1;
                        op_rh_wl   <= 1'b0;
                        op_addr    <= REG_BMCR;
                        op_wr_data <= PHY_RST_DATA;
                        busy       <= 1'b1;
                    end else if (go_cfg) begin
                        state      <= ST_CFG_ISS;
                        op_exec    <= 1'b1;
                        op_rh_wl   <= cfg_rh_wl;
                        op_addr    <= cfg_addr;
                        op_wr_data <= cfg_wdata;
                        busy       <= 1'b1;
                    end else if (go_poll) begin
                        state    <= ST_BMSR_ISS;
                        op_exec  <= 1'b1;
                        op_rh_wl <= 1'b1;
                        op_addr  <= REG_BMSR;
                        busy     <= 1'b1;
                    end
                end
                ST_RST_ISS:  state <= ST_RST_WAIT;
                ST_CFG_ISS:  state <= ST_CFG_WAIT;
                ST_BMSR_ISS: state <= ST_BMSR_WAIT;
                ST_SPD_ISS:  state <= ST_SPD_WAIT;
                ST_RST_WAIT: begin
                    if (op_done || wait_tmo) begin
                        link_up      <= 1'b0;
                        speed        <= SPD_10;
                        status_valid <= 1'b0;
                        err          <= ~op_done;
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                    end
                end
                ST_CFG_WAIT: begin
                    if (op_done || wait_tmo) begin
                        cfg_ack <= 1'b1;
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        if (!op_done || (op_rh_wl && op_rd_ack)) begin
                            cfg_rdata <= 16'hFFFF;
                            err       <= 1'b1;
                        end else if (op_rh_wl) begin
                            cfg_rdata <= op_rd_data;
                        end
                    end
                end
                ST_BMSR_WAIT: begin
                    if (rd_ok && bmsr_link(op_rd_data)) begin
                        // Link is up: chain the speed read without visiting IDLE.
                        state    <= ST_SPD_ISS;
                        op_exec  <= 1'b1;
                        op_rh_wl <= 1'b1;
                        op_addr  <= SPEED_REG;
                    end else if (rd_ok) begin
                        link_up      <= 1'b0;
                        status_valid <= 1'b1;
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                    end else if (op_done || wait_tmo) begin
                        err          <= 1'b1;
                        link_up      <= 1'b0;
                        status_valid <= 1'b0;
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                    end
                end
                ST_SPD_WAIT: begin
                    if (rd_ok) begin
                        link_up      <= 1'b1;
                        speed        <= op_rd_data[SPEED_LSB +: 2];
                        status_valid <= 1'b1;
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                    end else if (op_done || wait_tmo) begin
                        err          <= 1'b1;
                        link_up      <= 1'b0;
                        status_valid <= 1'b0;
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_mgmt_sched.sv
// Randomized bench for phy_mgmt_sched with a transaction-level driver/PHY model and scoreboard.
// Latency: driver answers each op_exec after 1..6 clocks (or never, when exercising the timeout).
// Backpressure: host holds cfg_req until cfg_ack, one request at a time.
module tb_phy_mgmt_sched;

    localparam int POLL = 64;
    localparam int TMO  = 40;

    typedef struct packed {
        logic        rh;
        logic [4:0]  addr;
        logic [15:0] wd;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_rst_trig = 1'b0;
    logic        cfg_req = 1'b0;
    logic        cfg_rh_wl = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        cfg_ack;
    logic [15:0] cfg_rdata;
    logic        op_exec;
    logic        op_rh_wl;
    logic [4:0]  op_addr;
    logic [15:0] op_wr_data;
    logic        op_done;
    logic [15:0] op_rd_data;
    logic        op_rd_ack;
    logic        link_up;
    logic [1:0]  speed;
    logic        status_valid;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    phy_mgmt_sched #(
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .soft_rst_trig (soft_rst_trig),
        .cfg_req       (cfg_req),
        .cfg_rh_wl     (cfg_rh_wl),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_ack       (cfg_ack),
        .cfg_rdata     (cfg_rdata),
        .op_exec       (op_exec),
        .op_rh_wl      (op_rh_wl),
        .op_addr       (op_addr),
        .op_wr_data    (op_wr_data),
        .op_done       (op_done),
        .op_rd_data    (op_rd_data),
        .op_rd_ack     (op_rd_ack),
        .link_up       (link_up),
        .speed         (speed),
        .status_valid  (status_valid),
        .busy          (busy),
        .err           (err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model state
    op_t         op_log[$];
    logic [15:0] preg[32];
    logic        exp_link = 1'b0;
    logic        exp_valid = 1'b0;
    logic [1:0]  exp_speed = 2'b00;
    logic [15:0] exp_rdata = 16'h0;
    bit          expect_spd = 0;
    bit          rst_exp = 0;
    time         rst_time = 0;
    bit          h_out = 0;
    time         h_time = 0;
    logic        h_rh = 1'b0;
    logic [4:0]  h_addr = '0;
    logic [15:0] h_wd = '0;
    int          exp_acks = 0;
    int          ack_cnt = 0;
    bit          drv_noresp = 0;
    bit          nack_bmsr = 0;
    bit          nack_cfg = 0;

    task automatic chk_reset_vals(input string pfx);
        chk_eq({pfx, "_op_exec"}, op_exec, 0);
        chk_eq({pfx, "_op_rh_wl"}, op_rh_wl, 1);
        chk_eq({pfx, "_op_addr"}, op_addr, 0);
        chk_eq({pfx, "_op_wr_data"}, op_wr_data, 0);
        chk_eq({pfx, "_cfg_ack"}, cfg_ack, 0);
        chk_eq({pfx, "_cfg_rdata"}, cfg_rdata, 0);
        chk_eq({pfx, "_link_up"}, link_up, 0);
        chk_eq({pfx, "_speed"}, speed, 0);
        chk_eq({pfx, "_status_valid"}, status_valid, 0);
        chk_eq({pfx, "_busy"}, busy, 0);
        chk_eq({pfx, "_err"}, err, 0);
    endtask

    // Driver/PHY model plus per-transaction scoreboard.
    initial begin : drv
        op_t         op;
        int          lat;
        int          k;
        logic [15:0] d;
        logic        nk;
        bit          is_rst, is_bmsr, is_spd, is_cfg, aborted, got;
        logic        e_err, e_ack, e_busy;
        op_done = 1'b0;
        op_rd_ack = 1'b0;
        op_rd_data = '0;
        forever begin
            if (!(rst_n && op_exec)) begin
                @(negedge clk);
                continue;
            end
            op = {op_rh_wl, op_addr, op_wr_data};
            op_log.push_back(op);
            is_rst  = !op.rh && op.addr == 5'h00;
            is_bmsr = op.rh && op.addr == 5'h01;
            is_spd  = op.rh && op.addr == 5'h11;
            is_cfg  = !(is_rst || is_bmsr || is_spd);
            // Arbitration order seen on the wire
            if (expect_spd) begin
                chk_eq("spd_follow", {op.rh, op.addr}, {1'b1, 5'h11});
                expect_spd = 0;
            end else if (rst_exp && rst_time < $time) begin
                chk_eq("prio_rst", op, {1'b0, 5'h00, 16'h9140});
            end else if (h_out && h_time < $time) begin
                chk_eq("prio_cfg", op, {h_rh, h_addr, h_rh ? op.wd : h_wd});
            end
            if (is_rst && rst_time < $time) rst_exp = 0;

            if (is_cfg && drv_noresp) begin
                aborted = 0; got = 0; k = 0;
                for (int j = 1; j <= TMO + 5; j++) begin
                    @(negedge clk);
                    k = j;
                    if (!rst_n) begin aborted = 1; break; end
                    if (cfg_ack) begin got = 1; break; end
                end
                if (!aborted) begin
                    chk_eq("tmo_ack", got, 1);
                    chk_eq("tmo_latency", k, TMO + 1);
                    chk_eq("tmo_rdata", cfg_rdata, 16'hFFFF);
                    chk_eq("tmo_err", err, 1);
                    chk_eq("tmo_busy", busy, 0);
                    exp_rdata = 16'hFFFF;
                    @(negedge clk);
                    chk_eq("tmo_ack_pulse", cfg_ack, 0);
                    chk_eq("tmo_err_pulse", err, 0);
                end
                continue;
            end

            lat = $urandom_range(1, 6);
            repeat (lat) @(negedge clk);
            if (!rst_n) continue;
            d  = op.rh ? preg[op.addr] : 16'($urandom);
            nk = (is_bmsr && nack_bmsr) || (is_cfg && op.rh && nack_cfg);
            op_done = 1'b1; op_rd_data = d; op_rd_ack = nk;
            @(negedge clk);
            op_done = 1'b0; op_rd_ack = 1'b0; op_rd_data = 16'($urandom);
            if (!rst_n) continue;

            e_err = 0; e_ack = 0; e_busy = 0;
            if (is_rst) begin
                exp_link = 0; exp_valid = 0; exp_speed = 2'b00;
            end else if (is_bmsr) begin
                if (nk) begin
                    e_err = 1; exp_link = 0; exp_valid = 0;
                end else if (d[2]) begin
                    expect_spd = 1; e_busy = 1;
                end else begin
                    exp_link = 0; exp_valid = 1;
                end
            end else if (is_spd) begin
                exp_link = 1; exp_valid = 1; exp_speed = d[15:14];
            end else begin
                e_ack = 1;
                if (op.rh) begin
                    if (nk) begin exp_rdata = 16'hFFFF; e_err = 1; end
                    else exp_rdata = d;
                end
            end
            chk_eq("done_err", err, e_err);
            chk_eq("done_cfg_ack", cfg_ack, e_ack);
            chk_eq("done_busy", busy, e_busy);
            chk_eq("done_link_up", link_up, exp_link);
            chk_eq("done_speed", speed, exp_speed);
            chk_eq("done_status_valid", status_valid, exp_valid);
            chk_eq("done_cfg_rdata", cfg_rdata, exp_rdata);
            if (expect_spd) chk_eq("spd_exec", op_exec, 1);
        end
    end

    // Pulse-width and ack-count monitor
    initial begin : mon
        logic prev_ack, prev_exec, prev_err;
        prev_ack = 0; prev_exec = 0; prev_err = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cfg_ack) begin ack_cnt++; chk_eq("ack_width", prev_ack, 0); end
                if (op_exec) chk_eq("exec_width", prev_exec, 0);
                if (err) chk_eq("err_width", prev_err, 0);
                prev_ack = cfg_ack; prev_exec = op_exec; prev_err = err;
            end else begin
                prev_ack = 0; prev_exec = 0; prev_err = 0;
            end
        end
    end

    task automatic pulse_soft_rst();
        soft_rst_trig = 1'b1; rst_exp = 1; rst_time = $time;
        @(negedge clk);
        soft_rst_trig = 1'b0;
    endtask

    // Host request, issued at a negedge; returns at the negedge cfg_ack is seen.
    task automatic host_req(input logic rh, input logic [4:0] a, input logic [15:0] wd, input bit with_rst);
        bit got;
        h_rh = rh; h_addr = a; h_wd = wd; h_time = $time; h_out = 1;
        cfg_rh_wl = rh; cfg_addr = a; cfg_wdata = wd; cfg_req = 1'b1;
        if (with_rst) begin soft_rst_trig = 1'b1; rst_exp = 1; rst_time = $time; end
        exp_acks++;
        got = 0;
        for (int j = 0; j < 800; j++) begin
            @(negedge clk);
            soft_rst_trig = 1'b0;
            if (cfg_ack) begin got = 1; break; end
        end
        if (!got) chk_eq("cfg_ack_wait", got, 1);
        cfg_req = 1'b0; h_out = 0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk_eq(tag, ok, 1);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          n, cnt, a0;
        bit          seen;
        logic [4:0]  a;
        for (int i = 0; i < 32; i++) preg[i] = 16'($urandom);
        preg[1]  = 16'h796D;
        preg[17] = 16'h8000;

        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Poll, link up: exactly BMSR then speed register
        seen = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (status_valid) begin seen = 1; break; end
        end
        chk_eq("poll_up_valid", seen, 1);
        chk_eq("poll_up_link", link_up, 1);
        chk_eq("poll_up_speed", speed, 2'b10);
        chk_eq("poll_up_nops", op_log.size(), 2);
        if (op_log.size() >= 2) begin
            chk_eq("poll_up_op0", {op_log[0].rh, op_log[0].addr}, {1'b1, 5'h01});
            chk_eq("poll_up_op1", {op_log[1].rh, op_log[1].addr}, {1'b1, 5'h11});
        end

        // Poll, link down: no speed register access, speed kept
        preg[1] = 16'h7969;
        n = op_log.size();
        seen = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (!link_up) begin seen = 1; break; end
        end
        chk_eq("poll_dn_seen", seen, 1);
        chk_eq("poll_dn_speed", speed, 2'b10);
        chk_eq("poll_dn_valid", status_valid, 1);
        cnt = 0;
        for (int j = n; j < op_log.size(); j++) if (op_log[j].addr == 5'h11) cnt++;
        chk_eq("poll_dn_no_spd", cnt, 0);

        // NACK on BMSR
        preg[1] = 16'h796D;
        nack_bmsr = 1;
        seen = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (err) begin seen = 1; break; end
        end
        chk_eq("nack_err", seen, 1);
        chk_eq("nack_link", link_up, 0);
        chk_eq("nack_valid", status_valid, 0);
        nack_bmsr = 0;

        // Soft reset and host write in the same IDLE cycle
        wait_idle("idle_sim");
        n = op_log.size();
        host_req(1'b0, 5'h1F, 16'h0A43, 1);
        chk_eq("sim_nops", op_log.size() >= n + 2, 1);
        if (op_log.size() >= n + 2) begin
            chk_eq("sim_op0", op_log[n], {1'b0, 5'h00, 16'h9140});
            chk_eq("sim_op1", op_log[n + 1], {1'b0, 5'h1F, 16'h0A43});
        end
        chk_eq("sim_link", link_up, 0);
        chk_eq("sim_valid", status_valid, 0);

        // Randomized mix
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 70)) @(negedge clk);
            preg[1]  = 16'($urandom);
            preg[17] = 16'($urandom);
            nack_cfg = ($urandom_range(0, 3) == 0);
            a = 5'($urandom_range(2, 31));
            if (a == 5'h11) a = 5'h12;
            case ($urandom_range(0, 5))
                0:       pulse_soft_rst();
                1:       host_req(1'($urandom), a, 16'($urandom), 1);
                default: host_req(1'($urandom), a, 16'($urandom), 0);
            endcase
        end
        nack_cfg = 0;

        // Host read timeout
        wait_idle("idle_tmo");
        drv_noresp = 1;
        host_req(1'b1, 5'h05, 16'h0, 0);
        drv_noresp = 0;

        // Async reset during CFG_WAIT
        wait_idle("idle_arst");
        drv_noresp = 1;
        n = op_log.size();
        h_rh = 1'b1; h_addr = 5'h03; h_wd = 16'h0; h_time = $time; h_out = 1;
        cfg_rh_wl = 1'b1; cfg_addr = 5'h03; cfg_wdata = 16'h0; cfg_req = 1'b1;
        seen = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (op_log.size() > n) begin seen = 1; break; end
        end
        chk_eq("arst_launch", seen, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        cfg_req = 1'b0; h_out = 0;
        exp_link = 0; exp_valid = 0; exp_speed = 2'b00; exp_rdata = 16'h0;
        expect_spd = 0; rst_exp = 0;
        repeat (3) @(negedge clk);
        drv_noresp = 0;
        rst_n = 1'b1;
        n = op_log.size();
        a0 = ack_cnt;
        repeat (60) @(negedge clk);
        chk_eq("arst_no_exec", op_log.size(), n);
        chk_eq("arst_no_ack", ack_cnt, a0);
        seen = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (op_log.size() > n) begin seen = 1; break; end
        end
        chk_eq("arst_next_poll", seen, 1);
        if (op_log.size() > n) chk_eq("arst_next_addr", op_log[n].addr, 5'h01);

        wait_idle("idle_end");
        repeat (10) @(negedge clk);
        chk_eq("ack_count", ack_cnt, exp_acks);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
